// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one combinational signed multiplier between two requesters.
// Latency: handshake in cycle c, rsp_valid high in cycle c+2; one op in flight, issue interval 3 cycles.
// Backpressure: rsp_valid/rsp_product/rsp_id held until rsp_ready; both req readies low while busy or holding.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   req0_valid/ready/a/b          requester 0 operand channel (signed N-bit operands)
//   req1_valid/ready/a/b          requester 1 operand channel (signed N-bit operands)
//   rsp_valid/ready/id/product    response channel, 2N-bit signed product tagged with requester id
// Optional build macro MULT_ARB_STATS_EN adds stats_clr input and grant_cnt0/grant_cnt1
// saturating 16-bit per-requester accept counters.

module multiplier #(
    parameter int N = 8
) (
    input  logic signed [N-1:0]   a,
    input  logic signed [N-1:0]   b,
    output logic signed [2*N-1:0] p
);
    // Both operands signed, so they are sign-extended to the 2N-bit result width:
    // the full product is exact, including most-negative squared.
    assign p = a * b;
endmodule

module mult_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_product
`ifdef MULT_ARB_STATS_EN
    ,
    input  logic           stats_clr,
    output logic [15:0]    grant_cnt0,
    output logic [15:0]    grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [N-1:0]         op_a;
    logic [N-1:0]         op_b;
    logic                 op_id;
    logic                 last_grant;
    logic                 sel0;
    logic                 sel1;
    logic                 accept;
    logic signed [2*N-1:0] mul_p;

    // Selection and next state. On a tie the requester that did not win last time is picked.
    always_comb begin
        sel0       = 1'b0;
        sel1       = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        state_nxt  = state;
        case (state)
            IDLE: begin
                sel0       = req0_valid & (~req1_valid | last_grant);
                sel1       = req1_valid & (~req0_valid | ~last_grant);
                req0_ready = sel0;
                req1_ready = sel1;
                if (sel0 | sel1)
                    state_nxt = BUSY;
            end
            BUSY: state_nxt = DONE;
            DONE: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = sel0 | sel1;

    multiplier #(.N(N)) u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= 1'b0;
            last_grant  <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_product <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a       <= sel1 ? req1_a : req0_a;
                op_b       <= sel1 ? req1_b : req0_b;
                op_id      <= sel1;
                last_grant <= sel1;
            end
            // Product captured from the operand flops after one full cycle through the multiplier.
            if (state == BUSY) begin
                rsp_product <= mul_p;
                rsp_id      <= op_id;
                rsp_valid   <= 1'b1;
            end else if (state == DONE && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef MULT_ARB_STATS_EN
    // Clear has priority over a coincident accept; counts stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else if (stats_clr) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else begin
            if (sel0 && grant_cnt0 != 16'hFFFF)
                grant_cnt0 <= grant_cnt0 + 16'd1;
            if (sel1 && grant_cnt1 != 16'hFFFF)
                grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: cycle model + scoreboard of expected {id, product}.
// Latency: model expects rsp_valid exactly two cycles after the handshake cycle.
// Backpressure: bench toggles rsp_ready and checks hold/stability and blocked readies.

module tb_mult_arbiter;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [2*N-1:0] rsp_product;
`ifdef MULT_ARB_STATS_EN
    logic           stats_clr;
    logic [15:0]    grant_cnt0, grant_cnt1;
    int             m_cnt0 = 0, m_cnt1 = 0;
`endif

    mult_arbiter #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product)
`ifdef MULT_ARB_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard (sampled on negedge) ----------------
    typedef enum {M_IDLE, M_BUSY, M_DONE} mstate_t;
    mstate_t     m_state = M_IDLE;
    logic        m_last = 1'b1;
    logic [16:0] exp_q[$];          // {id, product}
    logic        grant_log[$];
    int          acc_cyc[$];
    logic [15:0] last_prod = 16'd0;
    logic        last_id = 1'b0;
    int          acc_count = 0, rsp_count = 0, rsp_cyc = 0, cyc = 0;
    logic        e0, e1, mid;
    logic [7:0]  ma, mb;
    int          pp;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_state   = M_IDLE;
            m_last    = 1'b1;
            exp_q.delete();
            last_prod = 16'd0;
            last_id   = 1'b0;
`ifdef MULT_ARB_STATS_EN
            m_cnt0 = 0;
            m_cnt1 = 0;
`endif
        end else begin
            case (m_state)
                M_IDLE: begin
                    e0 = req0_valid && (!req1_valid || m_last);
                    e1 = req1_valid && (!req0_valid || !m_last);
                    check("idle_readies", {req1_ready, req0_ready}, {e1, e0});
                    check("idle_rsp_valid", rsp_valid, 0);
                    check("idle_hold_product", rsp_product, last_prod);
                    check("idle_hold_id", rsp_id, last_id);
`ifdef MULT_ARB_STATS_EN
                    if (stats_clr) begin
                        m_cnt0 = 0;
                        m_cnt1 = 0;
                    end else begin
                        if (e0 && m_cnt0 != 65535) m_cnt0++;
                        if (e1 && m_cnt1 != 65535) m_cnt1++;
                    end
`endif
                    if (e0 || e1) begin
                        mid = e1;
                        ma  = e1 ? req1_a : req0_a;
                        mb  = e1 ? req1_b : req0_b;
                        pp  = int'($signed(ma)) * int'($signed(mb));
                        exp_q.push_back({mid, pp[15:0]});
                        grant_log.push_back(mid);
                        acc_cyc.push_back(cyc);
                        acc_count++;
                        m_last  = mid;
                        m_state = M_BUSY;
                    end
                end
                M_BUSY: begin
                    check("busy_readies", {req1_ready, req0_ready}, 0);
                    check("busy_rsp_valid", rsp_valid, 0);
                    check("busy_hold_product", rsp_product, last_prod);
`ifdef MULT_ARB_STATS_EN
                    if (stats_clr) begin
                        m_cnt0 = 0;
                        m_cnt1 = 0;
                    end
`endif
                    m_state = M_DONE;
                end
                default: begin
                    check("done_readies", {req1_ready, req0_ready}, 0);
                    check("done_rsp_valid", rsp_valid, 1);
`ifdef MULT_ARB_STATS_EN
                    if (stats_clr) begin
                        m_cnt0 = 0;
                        m_cnt1 = 0;
                    end
`endif
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        check("rsp_id", rsp_id, exp_q[0][16]);
                        check("rsp_product", rsp_product, exp_q[0][15:0]);
                        if (rsp_ready) begin
                            last_id   = exp_q[0][16];
                            last_prod = exp_q[0][15:0];
                            void'(exp_q.pop_front());
                            rsp_count++;
                            rsp_cyc = cyc;
                        end
                    end
                    if (rsp_ready)
                        m_state = M_IDLE;
                end
            endcase
        end
    end

    // ---------------- stimulus helpers (drive at posedge + 1) ----------------
    task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b);
        int prev = acc_count;
        bit ok = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (acc_count != prev) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        // Operands change after the accept edge; the result must not follow them.
        if (id) begin
            req1_valid = 1'b0; req1_a = 8'($urandom); req1_b = 8'($urandom);
        end else begin
            req0_valid = 1'b0; req0_a = 8'($urandom); req0_b = 8'($urandom);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rsp_timeout", 0, 1);
    endtask

    task automatic wait_accepts(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (acc_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("multi_accept_timeout", 0, 1);
    endtask

    // ---------------- main sequence ----------------
    int base, prev_acc, prev_rsp;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
`ifdef MULT_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_product", rsp_product, 0);
        check("reset_readies", {req1_ready, req0_ready}, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;

        // Single request from requester 0: 3 * -5
        issue(1'b0, 8'd3, 8'hFB);
        wait_idle();
        check("t1_product", last_prod, 16'hFFF1);
        check("t1_id", last_id, 0);
        check("t1_valid_drop", rsp_valid, 0);

        // Corner operands; last one goes through requester 1
        issue(1'b0, 8'h80, 8'h80); wait_idle();
        check("corner_mneg_sq", last_prod, 16'h4000);
        issue(1'b0, 8'h80, 8'h7F); wait_idle();
        check("corner_mneg_mpos", last_prod, 16'hC080);
        issue(1'b0, 8'h00, 8'hFF); wait_idle();
        check("corner_zero", last_prod, 16'h0000);
        issue(1'b1, 8'h7F, 8'h7F); wait_idle();
        check("corner_mpos_sq", last_prod, 16'h3F01);
        check("corner_id1", last_id, 1);

        // Both valid continuously: alternation and 3-cycle issue interval
        base = grant_log.size();
        prev_acc = acc_count;
        req0_valid = 1'b1; req0_a = 8'd5;   req0_b = 8'd6;
        req1_valid = 1'b1; req1_a = 8'hF9;  req1_b = 8'd9;
        wait_accepts(prev_acc + 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        if (grant_log.size() >= base + 4) begin
            for (int i = 0; i < 4; i++)
                check("rr_grant_order", grant_log[base+i], i % 2);
            for (int i = 0; i < 3; i++)
                check("rr_issue_interval", acc_cyc[base+i+1] - acc_cyc[base+i], 3);
        end else begin
            check("rr_grant_count", grant_log.size() - base, 4);
        end
        check("rr_last_product", last_prod, 16'hFFC1);
        check("rr_last_id", last_id, 1);

        // Backpressure: result held 10 cycles while requester 1 waits
        rsp_ready = 1'b0;
        issue(1'b0, 8'hFD, 8'h04);
        req1_valid = 1'b1; req1_a = 8'd11; req1_b = 8'hFE;
        prev_acc = acc_count;
        repeat (10) @(posedge clk);
        #1;
        check("bp_no_accept", acc_count, prev_acc);
        check("bp_req1_ready", req1_ready, 0);
        check("bp_hold_product", rsp_product, 16'hFFF4);
        check("bp_hold_id", rsp_id, 0);
        rsp_ready = 1'b1;
        wait_accepts(prev_acc + 1);
        req1_valid = 1'b0;
        check("bp_accept_first_idle", acc_cyc[$] - rsp_cyc, 1);
        wait_idle();
        check("bp_req1_product", last_prod, 16'hFFEA);
        check("bp_req1_id", last_id, 1);

        // Reset while BUSY: op dropped, req0 wins first after release
        issue(1'b1, 8'h10, 8'h10);
        prev_rsp = rsp_count;
        #1 rst = 1'b1;
        #1;
        check("rstbusy_rsp_valid", rsp_valid, 0);
        check("rstbusy_rsp_product", rsp_product, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        base = grant_log.size();
        prev_acc = acc_count;
        req0_valid = 1'b1; req0_a = 8'd2;  req0_b = 8'd7;
        req1_valid = 1'b1; req1_a = 8'd4;  req1_b = 8'hFF;
        wait_accepts(prev_acc + 2);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        if (grant_log.size() >= base + 2) begin
            check("rst_first_grant", grant_log[base], 0);
            check("rst_second_grant", grant_log[base+1], 1);
        end else begin
            check("rst_grant_count", grant_log.size() - base, 2);
        end
        check("rst_no_dropped_rsp", rsp_count - prev_rsp, 2);

`ifdef MULT_ARB_STATS_EN
        check("stats_model_cnt0", grant_cnt0, m_cnt0);
        check("stats_model_cnt1", grant_cnt1, m_cnt1);
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin issue(1'b0, 8'd1, 8'd1); wait_idle(); end
        for (int i = 0; i < 3; i++) begin issue(1'b1, 8'd1, 8'd1); wait_idle(); end
        check("stats_cnt0_5", grant_cnt0, 5);
        check("stats_cnt1_3", grant_cnt1, 3);
        stats_clr = 1'b1;
        issue(1'b0, 8'd2, 8'd2);
        stats_clr = 1'b0;
        wait_idle();
        check("stats_clr_wins", grant_cnt0, 0);
        check("stats_clr_cnt1", grant_cnt1, 0);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
